// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates the single register-file write port between
// the ALU writeback path and the load-return path.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   alu_valid_i/rd_i/data_i      ALU writeback request
//   alu_ready_o                  ALU request accepted this cycle if valid
//   mem_valid_i/rd_i/data_i      load return, never back-pressured
//   rf_we_o/rf_rd_o/rf_data_o    registered register-file write port
//   chk_rd_i                     decode lookup index
//   chk_hit_o/chk_data_o         youngest pending write to chk_rd_i
//   fifo_cnt_o                   ALU holding FIFO occupancy
//
// Loads always win the port. ALU results that lose arbitration are queued
// in a small in-order FIFO and drain whenever no load is returning.
module regfile_wb_arbiter #(
   parameter int DWIDTH = 32,
   parameter int RWIDTH = 5,
   parameter int DEPTH  = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       alu_valid_i,
   input  logic [RWIDTH-1:0]          alu_rd_i,
   input  logic [DWIDTH-1:0]          alu_data_i,
   output logic                       alu_ready_o,
   input  logic                       mem_valid_i,
   input  logic [RWIDTH-1:0]          mem_rd_i,
   input  logic [DWIDTH-1:0]          mem_data_i,
   output logic                       rf_we_o,
   output logic [RWIDTH-1:0]          rf_rd_o,
   output logic [DWIDTH-1:0]          rf_data_o,
   input  logic [RWIDTH-1:0]          chk_rd_i,
   output logic                       chk_hit_o,
   output logic [DWIDTH-1:0]          chk_data_o,
   output logic [$clog2(DEPTH+1)-1:0] fifo_cnt_o
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [RWIDTH-1:0] q_rd   [DEPTH];
   logic [DWIDTH-1:0] q_data [DEPTH];
   logic [PW-1:0]     head_q;
   logic [PW-1:0]     tail_q;
   logic [CW-1:0]     cnt_q;

   logic              mem_hit;
   logic              alu_acc;
   logic              alu_nz;
   logic              fifo_ne;
   logic              push;
   logic              pop;
   logic              wr_en;
   logic [RWIDTH-1:0] wr_rd;
   logic [DWIDTH-1:0] wr_data;

   // Pointer increment wrapping modulo DEPTH (DEPTH need not be a power of 2)
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign mem_hit     = mem_valid_i && (mem_rd_i != '0);
   assign alu_ready_o = (cnt_q < CW'(DEPTH));
   assign alu_acc     = alu_valid_i && alu_ready_o;
   assign alu_nz      = alu_acc && (alu_rd_i != '0);
   assign fifo_ne     = (cnt_q != '0);
   assign fifo_cnt_o  = cnt_q;

   // Grant: load, then FIFO head, then ALU bypass
   always_comb begin
      wr_en   = 1'b0;
      wr_rd   = mem_rd_i;
      wr_data = mem_data_i;
      push    = 1'b0;
      pop     = 1'b0;
      if (mem_hit) begin
         wr_en = 1'b1;
         push  = alu_nz;
      end else if (fifo_ne) begin
         wr_en   = 1'b1;
         wr_rd   = q_rd[head_q];
         wr_data = q_data[head_q];
         pop     = 1'b1;
         push    = alu_nz;
      end else if (alu_nz) begin
         wr_en   = 1'b1;
         wr_rd   = alu_rd_i;
         wr_data = alu_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q    <= '0;
         tail_q    <= '0;
         cnt_q     <= '0;
         rf_we_o   <= 1'b0;
         rf_rd_o   <= '0;
         rf_data_o <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_rd[i]   <= '0;
            q_data[i] <= '0;
         end
      end else begin
         if (push) begin
            q_rd[tail_q]   <= alu_rd_i;
            q_data[tail_q] <= alu_data_i;
            tail_q         <= ptr_inc(tail_q);
         end
         if (pop) begin
            head_q <= ptr_inc(head_q);
         end
         cnt_q   <= cnt_q + CW'(push) - CW'(pop);
         rf_we_o <= wr_en;
         if (wr_en) begin
            rf_rd_o   <= wr_rd;
            rf_data_o <= wr_data;
         end
      end
   end

   // Lookup: walk oldest to youngest so the last match is the youngest;
   // the registered write is older than anything still in the FIFO.
   always_comb begin : lookup
      logic [PW-1:0] j;
      chk_hit_o  = 1'b0;
      chk_data_o = '0;
      j          = head_q;
      if (rf_we_o && (rf_rd_o == chk_rd_i)) begin
         chk_hit_o  = 1'b1;
         chk_data_o = rf_data_o;
      end
      for (int k = 0; k < DEPTH; k++) begin
         if ((CW'(k) < cnt_q) && (q_rd[j] == chk_rd_i)) begin
            chk_hit_o  = 1'b1;
            chk_data_o = q_data[j];
         end
         j = ptr_inc(j);
      end
      if (chk_rd_i == '0) begin
         chk_hit_o  = 1'b0;
         chk_data_o = '0;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed bench with a write-order scoreboard.
// Expected register writes are queued at stimulus time, checked on output.
module tb_regfile_wb_arbiter;

   logic        clk;
   logic        rst_n;
   logic        alu_valid_i;
   logic [4:0]  alu_rd_i;
   logic [31:0] alu_data_i;
   logic        alu_ready_o;
   logic        mem_valid_i;
   logic [4:0]  mem_rd_i;
   logic [31:0] mem_data_i;
   logic        rf_we_o;
   logic [4:0]  rf_rd_o;
   logic [31:0] rf_data_o;
   logic [4:0]  chk_rd_i;
   logic        chk_hit_o;
   logic [31:0] chk_data_o;
   logic [1:0]  fifo_cnt_o;

   int          errors;
   int          checks;
   logic [36:0] exp_q[$];

   regfile_wb_arbiter #(
      .DWIDTH(32),
      .RWIDTH(5),
      .DEPTH (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .alu_valid_i(alu_valid_i),
      .alu_rd_i   (alu_rd_i),
      .alu_data_i (alu_data_i),
      .alu_ready_o(alu_ready_o),
      .mem_valid_i(mem_valid_i),
      .mem_rd_i   (mem_rd_i),
      .mem_data_i (mem_data_i),
      .rf_we_o    (rf_we_o),
      .rf_rd_o    (rf_rd_o),
      .rf_data_o  (rf_data_o),
      .chk_rd_i   (chk_rd_i),
      .chk_hit_o  (chk_hit_o),
      .chk_data_o (chk_data_o),
      .fifo_cnt_o (fifo_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic mv, input logic [4:0] mrd,
                         input logic [31:0] md, input logic av,
                         input logic [4:0] ard, input logic [31:0] ad);
      mem_valid_i = mv;
      mem_rd_i    = mrd;
      mem_data_i  = md;
      alu_valid_i = av;
      alu_rd_i    = ard;
      alu_data_i  = ad;
   endtask

   task automatic idle();
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
      exp_q.push_back({rd, d});
   endtask

   // Scoreboard: every register write must be the next expected one
   always @(negedge clk) begin
      logic [36:0] e;
      if (rst_n && rf_we_o) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_wr", 64'({rf_rd_o, rf_data_o}), 64'(0));
         end else begin
            e = exp_q.pop_front();
            check("sb_write", 64'({rf_rd_o, rf_data_o}), 64'(e));
         end
      end
   end

   initial begin
      int idx;
      int n;
      errors   = 0;
      checks   = 0;
      rst_n    = 1'b0;
      chk_rd_i = 5'd0;
      idle();

      tick();
      check("rst_we", 64'(rf_we_o), 64'(0));
      check("rst_rd", 64'(rf_rd_o), 64'(0));
      check("rst_data", 64'(rf_data_o), 64'(0));
      check("rst_cnt", 64'(fifo_cnt_o), 64'(0));
      tick();
      rst_n = 1'b1;
      check("rst_ready", 64'(alu_ready_o), 64'(1));

      // Bypass
      set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hDEADBEEF);
      expect_wr(5'd3, 32'hDEADBEEF);
      tick();
      idle();
      check("byp_we", 64'(rf_we_o), 64'(1));
      check("byp_rd", 64'(rf_rd_o), 64'(3));
      check("byp_data", 64'(rf_data_o), 64'hDEADBEEF);
      check("byp_cnt", 64'(fifo_cnt_o), 64'(0));

      // Collision
      set_in(1'b1, 5'd7, 32'h1234, 1'b1, 5'd8, 32'h5678);
      expect_wr(5'd7, 32'h1234);
      expect_wr(5'd8, 32'h5678);
      tick();
      idle();
      check("col_rd1", 64'(rf_rd_o), 64'(7));
      check("col_cnt1", 64'(fifo_cnt_o), 64'(1));
      tick();
      check("col_rd2", 64'(rf_rd_o), 64'(8));
      check("col_data2", 64'(rf_data_o), 64'h5678);
      check("col_cnt2", 64'(fifo_cnt_o), 64'(0));
      tick();
      check("col_we_off", 64'(rf_we_o), 64'(0));

      // Back-pressure
      idx = 1;
      for (int c = 0; c < 4; c++) begin
         check("bp_ready", 64'(alu_ready_o), 64'(c < 2));
         set_in(1'b1, 5'(10 + c), 32'(256 + c),
                1'b1, 5'(idx), 32'(idx));
         expect_wr(5'(10 + c), 32'(256 + c));
         if (alu_ready_o) idx++;
         tick();
      end
      expect_wr(5'd1, 32'd1);
      expect_wr(5'd2, 32'd2);
      expect_wr(5'd3, 32'd3);
      check("bp_ready_c5", 64'(alu_ready_o), 64'(0));
      n = 0;
      while (idx <= 3 && n < 8) begin
         set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'(idx), 32'(idx));
         if (alu_ready_o) idx++;
         tick();
         n++;
      end
      idle();
      check("bp_all_accepted", 64'(idx), 64'(4));
      tick();
      tick();
      check("bp_drained", 64'(fifo_cnt_o), 64'(0));
      check("bp_we_off", 64'(rf_we_o), 64'(0));

      // x0 filtering
      set_in(1'b1, 5'd0, 32'h77, 1'b1, 5'd0, 32'hFFFF);
      tick();
      idle();
      check("x0_we", 64'(rf_we_o), 64'(0));
      check("x0_cnt", 64'(fifo_cnt_o), 64'(0));
      set_in(1'b1, 5'd0, 32'h77, 1'b1, 5'd4, 32'd9);
      expect_wr(5'd4, 32'd9);
      tick();
      idle();
      check("x0_byp_we", 64'(rf_we_o), 64'(1));
      check("x0_byp_rd", 64'(rf_rd_o), 64'(4));
      check("x0_byp_cnt", 64'(fifo_cnt_o), 64'(0));

      // Forwarding
      set_in(1'b1, 5'd20, 32'd1, 1'b1, 5'd9, 32'hA);
      expect_wr(5'd20, 32'd1);
      tick();
      set_in(1'b1, 5'd21, 32'd2, 1'b1, 5'd9, 32'hB);
      expect_wr(5'd21, 32'd2);
      tick();
      check("fw_cnt", 64'(fifo_cnt_o), 64'(2));
      set_in(1'b1, 5'd22, 32'd3, 1'b0, 5'd0, 32'd0);
      expect_wr(5'd22, 32'd3);
      expect_wr(5'd9, 32'hA);
      expect_wr(5'd9, 32'hB);
      chk_rd_i = 5'd9;
      #1;
      check("fw_hit9", 64'(chk_hit_o), 64'(1));
      check("fw_data9", 64'(chk_data_o), 64'hB);
      chk_rd_i = 5'd21;
      #1;
      check("fw_hit_rf", 64'(chk_hit_o), 64'(1));
      check("fw_data_rf", 64'(chk_data_o), 64'd2);
      chk_rd_i = 5'd0;
      #1;
      check("fw_hit0", 64'(chk_hit_o), 64'(0));
      check("fw_data0", 64'(chk_data_o), 64'(0));
      tick();
      idle();
      chk_rd_i = 5'd9;
      tick();
      check("fw_cnt1", 64'(fifo_cnt_o), 64'(1));
      check("fw_young", 64'(chk_data_o), 64'hB);
      tick();
      check("fw_rf_hit", 64'(chk_hit_o), 64'(1));
      check("fw_rf_data", 64'(chk_data_o), 64'hB);
      tick();
      check("fw_nohit", 64'(chk_hit_o), 64'(0));
      chk_rd_i = 5'd0;

      // Reset mid-drain
      set_in(1'b1, 5'd23, 32'h33, 1'b1, 5'd5, 32'h11);
      expect_wr(5'd23, 32'h33);
      tick();
      set_in(1'b1, 5'd24, 32'h44, 1'b1, 5'd6, 32'h22);
      expect_wr(5'd24, 32'h44);
      tick();
      check("rmd_cnt_full", 64'(fifo_cnt_o), 64'(2));
      set_in(1'b1, 5'd25, 32'h55, 1'b0, 5'd0, 32'd0);
      expect_wr(5'd25, 32'h55);
      tick();
      idle();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rmd_cnt", 64'(fifo_cnt_o), 64'(0));
      check("rmd_we", 64'(rf_we_o), 64'(0));
      check("rmd_rd", 64'(rf_rd_o), 64'(0));
      #1;
      rst_n = 1'b1;
      tick();
      check("rmd_ready", 64'(alu_ready_o), 64'(1));
      check("rmd_we_after", 64'(rf_we_o), 64'(0));
      repeat (4) tick();
      check("rmd_cnt_after", 64'(fifo_cnt_o), 64'(0));

      check("sb_empty", 64'(exp_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Arbitrates the single register-file write port between two producers: the ALU/immediate/PC+4 writeback path and the variable-latency load-return path.
- Load returns always win. ALU results that lose arbitration wait in a small in-order FIFO, and `alu_ready_o` back-pressures the pipeline when that FIFO is full.
- A lookup port lets decode detect pending writes and forward data still held in the FIFO.
- Sits between the writeback mux output and the register file write port.

Parameters:
- `DWIDTH`, 32: data width of a register write.
- `RWIDTH`, 5: register index width.
- `DEPTH`, 2: ALU holding FIFO entries; legal range 1..4.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `alu_valid_i`  in  1  ALU-side writeback request.
- `alu_rd_i`  in  RWIDTH  ALU destination register.
- `alu_data_i`  in  DWIDTH  ALU-side writeback data.
- `alu_ready_o`  out  1  ALU request accepted this cycle if valid.
- `mem_valid_i`  in  1  load-return write request; never back-pressured.
- `mem_rd_i`  in  RWIDTH  load destination register.
- `mem_data_i`  in  DWIDTH  load data.
- `rf_we_o`  out  1  register-file write enable (registered).
- `rf_rd_o`  out  RWIDTH  register-file write index (registered).
- `rf_data_o`  out  DWIDTH  register-file write data (registered).
- `chk_rd_i`  in  RWIDTH  decode lookup register index.
- `chk_hit_o`  out  1  `chk_rd_i` is non-zero and matches a FIFO entry or the current `rf_*` write.
- `chk_data_o`  out  DWIDTH  data of the youngest match; 0 when no hit.
- `fifo_cnt_o`  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (`rst_n` low, asynchronous, any time including mid-drain):
  - FIFO flushed, count = 0.
  - `rf_we_o` = 0, `rf_rd_o` = 0, `rf_data_o` = 0.
  - `alu_ready_o` = 1 once released.
  - In-flight entries are lost; upstream is reset together.
- ALU handshake:
  - `alu_ready_o` = (count < DEPTH). It is derived from registered state only and never depends on `alu_valid_i`.
  - Accept = `alu_valid_i` & `alu_ready_o`.
  - An accepted request with `alu_rd_i` == 0 is silently dropped: not enqueued, never writes.
- Per-cycle grant, evaluated combinationally and registered into `rf_*` at the clock edge. Priority order:
  1. `mem_valid_i` & `mem_rd_i` != 0: write the load. Any accepted non-zero ALU request is enqueued at the FIFO tail.
  2. Else FIFO non-empty: write the FIFO head and pop it. Any accepted ALU request is enqueued at the tail.
  3. Else accepted ALU request with rd != 0: bypass the FIFO and write directly.
  4. Else `rf_we_o` <= 0. `rf_rd_o` and `rf_data_o` hold their previous values.
- A load with `mem_rd_i` == 0 is discarded and does not consume the port.
- Latency: one cycle from accept/grant to `rf_we_o` high. One write per cycle maximum.
- FIFO:
  - Circular buffer with head/tail pointers wrapping modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - Push when full cannot occur because ready is low.
  - ALU writes retire strictly in acceptance order.
- Ordering across sources follows grant order. The pipeline interlock guarantees no WAW hazard between an in-flight load and a queued ALU op to the same rd; this block does not check for it.
- Lookup (combinational):
  - Search order is youngest first: FIFO tail-1 back to head, then the registered `rf_*` if `rf_we_o` is high.
  - `chk_rd_i` == 0 gives no hit.
- Sustained `mem_valid_i` can starve the FIFO indefinitely; `alu_ready_o` stays low while full. This is intended, since the load unit cannot stall.

Test Plan:
- Reset mid-drain: fill FIFO with x5=0x11 and x6=0x22 under continuous loads, then pulse `rst_n` low → `fifo_cnt_o`=0, `rf_we_o`=0 immediately; after release, `alu_ready_o`=1 and neither value is ever written.
- Bypass: idle, ALU x3=0xDEADBEEF → next cycle `rf_we_o`=1, `rf_rd_o`=3, `rf_data_o`=0xDEADBEEF; `fifo_cnt_o` stays 0.
- Collision: same cycle mem x7=0x1234 and ALU x8=0x5678 → cycle+1 writes x7=0x1234, cycle+2 writes x8=0x5678; `fifo_cnt_o` goes 1 then 0.
- Back-pressure (DEPTH=2): loads for 4 consecutive cycles plus ALU valid every cycle with x1=1, x2=2, x3=3 → `alu_ready_o` low from cycle 3; after loads stop, writes occur x1, x2, x3 in order with no loss or duplication.
- x0 filtering: ALU rd=0 data=0xFFFF and mem rd=0 → `rf_we_o` never asserts; `fifo_cnt_o` unchanged; a simultaneous ALU x4=9 bypasses and writes next cycle.
- Forwarding: FIFO holds x9=0xA then x9=0xB, `chk_rd_i`=9 → `chk_hit_o`=1, `chk_data_o`=0xB; `chk_rd_i`=0 → `chk_hit_o`=0, `chk_data_o`=0.
